// File: rtl/hash_feeder_pkg.sv
// Shared widths, defaults and FSM state type for the hash message feeder.
package hash_feeder_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned LEN_W           = 64;
    localparam int unsigned DIGEST_W        = 32;
    localparam int unsigned DEF_BYTE_CYCLES = 3;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FEED      = 3'd1,
        GAP       = 3'd2,
        WAIT_HASH = 3'd3,
        OUT       = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/hash_byte_fifo.sv
// Byte-wide synchronous FIFO with registered full/empty flags and a
// first-word-fall-through head.
module hash_byte_fifo
    import hash_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_pop,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_count_nxt;

    // Flags are registered, so a push at full is refused even alongside a pop.
    assign w_push  = i_push && !r_full;
    assign w_pop   = i_pop && !r_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/hash_msg_feeder.sv
// Host-side feeder for the hash core: takes a length and byte stream, paces
// bytes into the core one per iteration, and hands the digest back.
module hash_msg_feeder
    import hash_feeder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned BYTE_CYCLES = DEF_BYTE_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [LEN_W-1:0]    msg_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BYTE_W-1:0]   in_data,
    output logic                core_m_valid,
    output logic [BYTE_W-1:0]   core_message,
    output logic [LEN_W-1:0]    core_counter,
    input  logic                core_hash_ready,
    input  logic [DIGEST_W-1:0] core_digest,
    output logic                dig_valid,
    input  logic                dig_ready,
    output logic [DIGEST_W-1:0] digest,
    output logic                busy,
    output logic                err_zero_len
);
    localparam int unsigned GAP_W = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;

    feeder_state_t       r_state;
    feeder_state_t       w_state_nxt;
    logic [LEN_W-1:0]    r_len_q;
    logic [LEN_W-1:0]    w_len_nxt;
    logic [LEN_W-1:0]    r_acc_rem;
    logic [LEN_W-1:0]    w_acc_nxt;
    logic [LEN_W-1:0]    r_feed_rem;
    logic [LEN_W-1:0]    w_feed_nxt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [GAP_W-1:0]    w_gap_nxt;
    logic                r_m_valid;
    logic                w_m_valid_nxt;
    logic [BYTE_W-1:0]   r_message;
    logic [BYTE_W-1:0]   w_message_nxt;
    logic                r_dig_valid;
    logic                w_dig_valid_nxt;
    logic [DIGEST_W-1:0] r_digest;
    logic [DIGEST_W-1:0] w_digest_nxt;
    logic                r_err;
    logic                w_err_nxt;

    logic                w_push;
    logic                w_pop;
    logic [BYTE_W-1:0]   w_fifo_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    hash_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Handshake decodes come straight from registered state.
    assign start_ready  = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign in_ready     = (r_state != IDLE) && (r_state != OUT) &&
                          !w_fifo_full && (r_acc_rem != '0);
    assign w_push       = in_valid && in_ready;

    assign core_m_valid = r_m_valid;
    assign core_message = r_message;
    assign core_counter = r_len_q;
    assign dig_valid    = r_dig_valid;
    assign digest       = r_digest;
    assign err_zero_len = r_err;

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len_q;
        w_acc_nxt       = r_acc_rem;
        w_feed_nxt      = r_feed_rem;
        w_gap_nxt       = r_gap_cnt;
        w_m_valid_nxt   = 1'b0;
        w_message_nxt   = r_message;
        w_dig_valid_nxt = r_dig_valid;
        w_digest_nxt    = r_digest;
        w_err_nxt       = 1'b0;
        w_pop           = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start_valid) begin
                    if (msg_len == '0) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_len_nxt   = msg_len;
                        w_acc_nxt   = msg_len;
                        w_feed_nxt  = msg_len;
                        w_state_nxt = FEED;
                    end
                end
            end
            FEED: begin
                if (!w_fifo_empty) begin
                    w_pop         = 1'b1;
                    w_m_valid_nxt = 1'b1;
                    w_message_nxt = w_fifo_head;
                    w_feed_nxt    = r_feed_rem - LEN_W'(1);
                    w_gap_nxt     = GAP_W'(BYTE_CYCLES - 1);
                    w_state_nxt   = GAP;
                end
            end
            // Hold off the next byte until the core finishes its iteration.
            GAP: begin
                w_gap_nxt = r_gap_cnt - GAP_W'(1);
                if (r_gap_cnt == GAP_W'(1)) begin
                    w_state_nxt = (r_feed_rem == '0) ? WAIT_HASH : FEED;
                end
            end
            WAIT_HASH: begin
                if (core_hash_ready) begin
                    w_digest_nxt    = core_digest;
                    w_dig_valid_nxt = 1'b1;
                    w_state_nxt     = OUT;
                end
            end
            OUT: begin
                if (dig_ready) begin
                    w_dig_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // No push is possible in IDLE, so this never collides with the load.
        if (w_push) w_acc_nxt = r_acc_rem - LEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_len_q     <= '0;
            r_acc_rem   <= '0;
            r_feed_rem  <= '0;
            r_gap_cnt   <= '0;
            r_m_valid   <= 1'b0;
            r_message   <= '0;
            r_dig_valid <= 1'b0;
            r_digest    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len_q     <= w_len_nxt;
            r_acc_rem   <= w_acc_nxt;
            r_feed_rem  <= w_feed_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_message   <= w_message_nxt;
            r_dig_valid <= w_dig_valid_nxt;
            r_digest    <= w_digest_nxt;
            r_err       <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Bench for hash_msg_feeder: a transaction-level model predicts every output
// each cycle, and directed scenarios pin it with hand-computed literals.
module tb_hash_msg_feeder;
    import hash_feeder_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BC    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [63:0] msg_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        core_m_valid;
    logic [7:0]  core_message;
    logic [63:0] core_counter;
    logic        core_hash_ready = 1'b0;
    logic [31:0] core_digest = '0;
    logic        dig_valid;
    logic        dig_ready = 1'b0;
    logic [31:0] digest;
    logic        busy;
    logic        err_zero_len;

    always #5 clk = ~clk;

    hash_msg_feeder #(.FIFO_DEPTH(DEPTH), .BYTE_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready), .msg_len(msg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_m_valid(core_m_valid), .core_message(core_message), .core_counter(core_counter),
        .core_hash_ready(core_hash_ready), .core_digest(core_digest),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .digest(digest),
        .busy(busy), .err_zero_len(err_zero_len)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Model: message in flight, bytes accepted/fed/buffered, spacing since last feed.
    bit          m_on = 1'b0;
    bit          m_busy, m_mv, m_dv, m_err;
    logic [63:0] m_len, m_cnt, m_acc, m_fed, m_buf;
    int          m_since;
    logic [7:0]  m_msg;
    logic [31:0] m_dig;
    logic [7:0]  m_q[$];
    bit          md_rdy, md_push, md_pop, md_cap, md_take, md_start;

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            m_on = 1'b1; m_busy = 1'b0; m_mv = 1'b0; m_dv = 1'b0; m_err = 1'b0;
            m_len = '0; m_cnt = '0; m_acc = '0; m_fed = '0; m_buf = '0;
            m_since = 0; m_msg = '0; m_dig = '0; m_q.delete();
        end else begin
            md_rdy   = m_busy && (m_acc < m_len) && (m_buf < 64'(DEPTH));
            md_push  = in_valid && md_rdy;
            md_pop   = m_busy && !m_dv && (m_fed < m_len) && (m_buf != 0) &&
                       ((m_fed == 0) || (m_since >= int'(BC) - 1));
            md_cap   = m_busy && !m_dv && (m_fed == m_len) && (m_fed != 0) &&
                       (m_since >= int'(BC) - 1) && core_hash_ready;
            md_take  = m_dv && dig_ready;
            md_start = !m_busy && start_valid;
            m_err = md_start && (msg_len == 0);
            m_mv  = md_pop;
            if (md_pop) begin
                m_msg = m_q.pop_front(); m_fed++; m_buf--; m_since = 0;
            end else begin
                m_since++;
            end
            if (md_push) begin
                m_q.push_back(in_data); m_acc++; m_buf++;
            end
            if (md_cap) begin
                m_dv = 1'b1; m_dig = core_digest;
            end
            if (md_take) begin
                m_dv = 1'b0; m_busy = 1'b0;
            end
            if (md_start && msg_len != 0) begin
                m_busy = 1'b1; m_len = msg_len; m_cnt = msg_len;
                m_acc = '0; m_fed = '0; m_buf = '0; m_q.delete();
            end
        end
    end

    logic [7:0]  obs_msg[$];
    logic [63:0] obs_cnt[$];
    int          obs_cyc[$];
    int          err_seen = 0;

    always @(negedge clk) begin
        if (m_on) begin
            chk("start_ready", 64'(start_ready), 64'(!m_busy));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("in_ready", 64'(in_ready), 64'(m_busy && (m_acc < m_len) && (m_buf < 64'(DEPTH))));
            chk("core_m_valid", 64'(core_m_valid), 64'(m_mv));
            chk("core_message", 64'(core_message), 64'(m_msg));
            chk("core_counter", core_counter, m_cnt);
            chk("dig_valid", 64'(dig_valid), 64'(m_dv));
            chk("digest", 64'(digest), 64'(m_dig));
            chk("err_zero_len", 64'(err_zero_len), 64'(m_err));
            if (core_m_valid) begin
                obs_msg.push_back(core_message);
                obs_cnt.push_back(core_counter);
                obs_cyc.push_back(cyc);
            end
            if (err_zero_len) err_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_msg.delete(); obs_cnt.delete(); obs_cyc.delete(); err_seen = 0;
    endtask

    task automatic start_msg(input logic [63:0] len);
        start_valid = 1'b1; msg_len = len;
        tick();
        start_valid = 1'b0; msg_len = '0;
    endtask

    task automatic push_bytes(input logic [7:0] b[$], output int refused);
        int guard;
        bit done;
        refused = 0;
        foreach (b[i]) begin
            in_valid = 1'b1; in_data = b[i];
            guard = 0; done = 1'b0;
            while (!done && guard < 50) begin
                done = in_ready;
                if (!done) refused++;
                tick();
                guard++;
            end
            if (!done) timeout("push");
        end
        in_valid = 1'b0; in_data = '0;
    endtask

    task automatic wait_pulses(input int n);
        int guard = 0;
        while (obs_msg.size() < n && guard < 80) begin
            tick(); guard++;
        end
        if (obs_msg.size() < n) timeout("wait_pulses");
    endtask

    task automatic hash_return(input logic [31:0] d);
        repeat (5) tick();
        core_hash_ready = 1'b1; core_digest = d;
        tick();
        core_hash_ready = 1'b0; core_digest = '0;
    endtask

    task automatic take_digest(input int hold, input bit poke, input logic [31:0] want);
        int guard = 0;
        while (!dig_valid && guard < 40) begin
            tick(); guard++;
        end
        if (!dig_valid) timeout("wait_dig");
        chk("dig_lit", 64'(digest), 64'(want));
        repeat (hold) begin
            start_valid = poke; msg_len = poke ? 64'd7 : 64'd0;
            tick();
            chk("hold_dig_valid", 64'(dig_valid), 64'd1);
            chk("hold_digest", 64'(digest), 64'(want));
            chk("hold_start_ready", 64'(start_ready), 64'd0);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        start_valid = 1'b0; msg_len = '0;
        dig_ready = 1'b1;
        tick();
        dig_ready = 1'b0;
        chk("released_dig_valid", 64'(dig_valid), 64'd0);
        chk("released_start_ready", 64'(start_ready), 64'd1);
    endtask

    initial begin
        logic [7:0] q[$];
        int refused;

        tick(); tick();
        rst_n = 1'b0;
        chk("rst_start_ready", 64'(start_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_counter", core_counter, 64'd0);
        chk("rst_digest", 64'(digest), 64'd0);

        // Single byte message.
        clear_obs();
        q = {8'h61};
        start_msg(64'd1);
        push_bytes(q, refused);
        wait_pulses(1);
        hash_return(32'hDEADBEEF);
        take_digest(0, 1'b0, 32'hDEADBEEF);
        chk("t1_npulse", 64'(obs_msg.size()), 64'd1);
        chk("t1_msg", 64'(obs_msg[0]), 64'h61);
        chk("t1_cnt", obs_cnt[0], 64'd1);

        // Three bytes back to back: exact cadence.
        clear_obs();
        q = {8'h41, 8'h42, 8'h43};
        start_msg(64'd3);
        push_bytes(q, refused);
        wait_pulses(3);
        hash_return(32'hCAFEF00D);
        take_digest(0, 1'b0, 32'hCAFEF00D);
        chk("t2_npulse", 64'(obs_msg.size()), 64'd3);
        chk("t2_msg0", 64'(obs_msg[0]), 64'h41);
        chk("t2_msg1", 64'(obs_msg[1]), 64'h42);
        chk("t2_msg2", 64'(obs_msg[2]), 64'h43);
        chk("t2_space01", 64'(obs_cyc[1] - obs_cyc[0]), 64'd3);
        chk("t2_space12", 64'(obs_cyc[2] - obs_cyc[1]), 64'd3);
        chk("t2_cnt2", obs_cnt[2], 64'd3);

        // Six bytes, no host gaps.
        clear_obs();
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'(8'h30 + i));
        start_msg(64'd6);
        push_bytes(q, refused);
        chk("t3_refused", 64'(refused), 64'd0);
        wait_pulses(6);
        hash_return(32'h12345678);
        take_digest(0, 1'b0, 32'h12345678);
        chk("t3_npulse", 64'(obs_msg.size()), 64'd6);
        for (int i = 0; i < 6; i++) chk("t3_order", 64'(obs_msg[i]), 64'(8'h30 + i));

        // Eight bytes: FIFO fills and throttles the host.
        clear_obs();
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(8'(8'h30 + i));
        start_msg(64'd8);
        push_bytes(q, refused);
        chk("t3b_refused", 64'(refused), 64'd4);
        wait_pulses(8);
        hash_return(32'h0F1E2D3C);
        take_digest(0, 1'b0, 32'h0F1E2D3C);
        chk("t3b_last", 64'(obs_msg[7]), 64'h37);

        // Zero length, plus a stray hash_ready while idle.
        clear_obs();
        core_hash_ready = 1'b1; core_digest = 32'hBAD0BAD0;
        tick();
        core_hash_ready = 1'b0; core_digest = '0;
        start_msg(64'd0);
        chk("t4_err", 64'(err_zero_len), 64'd1);
        chk("t4_start_ready", 64'(start_ready), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        tick();
        chk("t4_err_clear", 64'(err_zero_len), 64'd0);
        repeat (4) tick();
        chk("t4_err_once", 64'(err_seen), 64'd1);
        chk("t4_no_pulse", 64'(obs_msg.size()), 64'd0);
        chk("t4_dig_valid", 64'(dig_valid), 64'd0);

        // Reset in GAP after two of five bytes.
        clear_obs();
        q = {8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
        start_msg(64'd5);
        push_bytes(q, refused);
        wait_pulses(2);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("t5_m_valid", 64'(core_m_valid), 64'd0);
        chk("t5_dig_valid", 64'(dig_valid), 64'd0);
        chk("t5_start_ready", 64'(start_ready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_counter", core_counter, 64'd0);
        repeat (6) tick();
        chk("t5_npulse", 64'(obs_msg.size()), 64'd2);
        clear_obs();
        q = {8'h77};
        start_msg(64'd1);
        push_bytes(q, refused);
        wait_pulses(1);
        hash_return(32'h0BADCAFE);
        take_digest(0, 1'b0, 32'h0BADCAFE);
        chk("t5b_npulse", 64'(obs_msg.size()), 64'd1);
        chk("t5b_msg", 64'(obs_msg[0]), 64'h77);

        // Host stalls the digest; a start offered meanwhile is ignored.
        clear_obs();
        q = {8'h5A};
        start_msg(64'd1);
        push_bytes(q, refused);
        wait_pulses(1);
        hash_return(32'h600DF00D);
        take_digest(10, 1'b1, 32'h600DF00D);
        chk("t6_counter", core_counter, 64'd1);
        tick();
        chk("t6_idle", 64'(busy), 64'd0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hash_msg_feeder.md
Name: hash_msg_feeder

Overview:
Upstream stage of full_hash_des_box. It accepts a message-length command and a byte stream from the host over valid/ready handshakes, and buffers bytes in a small FIFO. It drives the core's message / M_valid / counter inputs, one byte per core iteration. It waits for the core's hash_ready, captures the 32-bit digest, and returns it to the host over a valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, byte FIFO entries (power of 2, >=2)
BYTE_CYCLES, 3, minimum clk cycles between consecutive core_m_valid pulses (core S0->S1->S2 cadence)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-high (asserted = 1)
start_valid  in  1  host offers new message length
start_ready  out  1  feeder accepts length (IDLE only)
msg_len  in  64  message length in bytes
in_valid  in  1  host byte valid
in_ready  out  1  feeder accepts byte
in_data  in  8  message byte (ASCII)
core_m_valid  out  1  one-cycle pulse to core M_valid
core_message  out  8  byte to core message
core_counter  out  64  latched msg_len to core counter
core_hash_ready  in  1  core hash_ready
core_digest  in  32  core digest_out
dig_valid  out  1  digest available to host
dig_ready  in  1  host takes digest
digest  out  32  captured digest
busy  out  1  high in any state except IDLE
err_zero_len  out  1  one-cycle pulse: msg_len==0 rejected

Behaviour:
- Reset (rst_n=1 at a rising edge): state IDLE; FIFO empty; all counters 0. Outputs: start_ready=1, in_ready=0, core_m_valid=0, core_message=0, core_counter=0, dig_valid=0, digest=0, busy=0, err_zero_len=0. Reset mid-operation aborts the message; no digest is produced.
- Registers: len_q[63:0], acc_rem[63:0] (bytes still to accept), feed_rem[63:0] (bytes still to feed), gap_cnt (clog2(BYTE_CYCLES) bits). Counters only decrement; they never wrap.
- All core_* outputs and dig_valid/digest are registered.
- State IDLE:
  - start_ready=1.
  - On start_valid with msg_len==0: err_zero_len=1 next cycle; stay in IDLE.
  - On start_valid with msg_len!=0: len_q, acc_rem and feed_rem are loaded with msg_len; core_counter<=msg_len; go to FEED.
- in_ready = (state!=IDLE && state!=OUT) && !fifo_full && acc_rem!=0.
  - Push on in_valid&in_ready; acc_rem decrements.
  - Bytes beyond msg_len are never accepted.
  - fifo_full is registered, so a push is refused at full even if a pop occurs in the same cycle.
- State FEED:
  - If FIFO is non-empty: pop the head; next cycle core_m_valid=1 and core_message=head. feed_rem decrements, gap_cnt<=BYTE_CYCLES-1, go to GAP.
  - If FIFO is empty: wait in FEED with core_m_valid=0.
- State GAP:
  - core_m_valid=0; gap_cnt decrements.
  - At gap_cnt==1: go to WAIT_HASH if feed_rem==0, else go to FEED.
  - Consecutive core_m_valid pulses are therefore exactly BYTE_CYCLES apart when the FIFO never runs dry.
- State WAIT_HASH:
  - On core_hash_ready=1: digest<=core_digest, dig_valid<=1, go to OUT.
  - core_hash_ready seen in any other state is ignored.
- State OUT:
  - dig_valid and digest are held stable until dig_ready; then dig_valid<=0, go to IDLE.
  - dig_valid and dig_ready high in the same cycle completes the transfer.
- core_counter holds len_q for the whole message. It is updated only at start acceptance.
- Latency: a byte pushed at edge t can appear on core_message at earliest cycle t+2 (FIFO write, then FEED pop).
- Simultaneous start_valid and in_valid in IDLE: in_ready=0, so the byte is not consumed until FEED.

Decomposition:
- Package hash_feeder_pkg holds:
  - feeder_state_t enum (IDLE, FEED, GAP, WAIT_HASH, OUT);
  - BYTE_W=8, LEN_W=64, DIGEST_W=32;
  - default BYTE_CYCLES=3.
- Sub-module hash_byte_fifo: synchronous FIFO with parameter DEPTH, 8-bit wide, push/pop/full/empty, cleared by rst_n. The top level holds the FSM and counters.

Test Plan:
- len=1, byte 0x61, core model returns hash_ready with 0xDEADBEEF -> one core_m_valid pulse with message=0x61, counter=1; dig_valid=1 with digest=0xDEADBEEF until dig_ready.
- len=3, bytes 0x41 0x42 0x43 back-to-back -> core_m_valid pulses exactly 3 cycles apart, counter=3 on every pulse; in_ready=0 after the 3rd byte; no 4th pulse.
- len=6, host pushes 6 bytes with no gaps -> in_ready drops when 4 bytes are buffered; all 6 bytes reach the core in order 0x30..0x35.
- msg_len=0 -> err_zero_len pulses 1 cycle; start_ready stays 1; busy=0; no core_m_valid.
- rst_n=1 in GAP after 2 of 5 bytes -> next cycle IDLE, FIFO empty, core_m_valid=0, dig_valid=0; a later len=1 message completes normally.
- dig_ready held 0 for 10 cycles in OUT -> digest and dig_valid stable; start_ready=0; in_ready=0; a start_valid during OUT is ignored.
